// File: rtl/stream_i64_source.sv
// rtl/stream_i64_source.sv - handshaked i64 arithmetic-sequence stream generator with EOS beat and completion token
module stream_i64_source #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inCtrl_valid,
    output logic                   inCtrl_ready,
    input  logic [DATA_WIDTH-1:0]  cfg_base,
    input  logic [DATA_WIDTH-1:0]  cfg_step,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [DATA_WIDTH-1:0]  out0_data_field0,
    output logic                   out0_data_field1,
    output logic                   outCtrl_valid,
    input  logic                   outCtrl_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_EOS  = 2'd2,
        ST_CTRL = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  r_cur;
    logic [DATA_WIDTH-1:0]  r_step;
    logic [COUNT_WIDTH-1:0] r_remaining;

    logic w_start;
    logic w_beat;

    // Handshake qualifiers; only the state-owned valid side matters, so these are one AND each.
    assign w_start = (r_state == ST_IDLE) && inCtrl_valid;
    assign w_beat  = (r_state == ST_EMIT) && out0_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode; outputs depend only on registered state and r_cur.
    always_comb begin
        w_state_next     = r_state;
        inCtrl_ready     = 1'b0;
        out0_valid       = 1'b0;
        out0_data_field0 = '0;
        out0_data_field1 = 1'b0;
        outCtrl_valid    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                inCtrl_ready = 1'b1;
                if (inCtrl_valid) begin
                    w_state_next = (cfg_count != '0) ? ST_EMIT : ST_EOS;
                end
            end
            ST_EMIT: begin
                out0_valid       = 1'b1;
                out0_data_field0 = r_cur;
                if (out0_ready && (r_remaining == COUNT_WIDTH'(1))) begin
                    w_state_next = ST_EOS;
                end
            end
            ST_EOS: begin
                out0_valid       = 1'b1;
                out0_data_field1 = 1'b1;
                if (out0_ready) begin
                    w_state_next = ST_CTRL;
                end
            end
            ST_CTRL: begin
                outCtrl_valid = 1'b1;
                if (outCtrl_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture configuration on the start handshake, advance the sequence on each accepted data beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur       <= '0;
            r_step      <= '0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_cur       <= cfg_base;
            r_step      <= cfg_step;
            r_remaining <= cfg_count;
        end else if (w_beat) begin
            r_cur       <= r_cur + r_step;
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_i64_source.sv
// tb/tb_stream_i64_source.sv - randomized self-checking bench for stream_i64_source
module tb_stream_i64_source;

    logic        clock;
    logic        reset;
    logic        inCtrl_valid;
    logic        inCtrl_ready;
    logic [63:0] cfg_base;
    logic [63:0] cfg_step;
    logic [15:0] cfg_count;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out0_data_field0;
    logic        out0_data_field1;
    logic        outCtrl_valid;
    logic        outCtrl_ready;

    int errors = 0;
    int checks = 0;

    stream_i64_source #(
        .DATA_WIDTH (64),
        .COUNT_WIDTH(16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .inCtrl_valid    (inCtrl_valid),
        .inCtrl_ready    (inCtrl_ready),
        .cfg_base        (cfg_base),
        .cfg_step        (cfg_step),
        .cfg_count       (cfg_count),
        .out0_valid      (out0_valid),
        .out0_ready      (out0_ready),
        .out0_data_field0(out0_data_field0),
        .out0_data_field1(out0_data_field1),
        .outCtrl_valid   (outCtrl_valid),
        .outCtrl_ready   (outCtrl_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One full run. Expected beat k is base + k*step (mod 2^64) for k < count, then the EOS beat.
    // mode 0: out0_ready follows pat (LSB first) for pat_len cycles then 1; mode 1: random ready.
    task automatic run_stream(input logic [63:0] base, input logic [63:0] step, input int count,
                              input int mode, input logic [31:0] pat, input int pat_len,
                              input int ctrl_stall, input bit hold_valid);
        int          k;
        int          cyc;
        int          budget;
        logic        rdy;
        logic        done;
        logic [63:0] exp_d;
        logic        exp_e;
        @(negedge clock);
        checks++;
        if (inCtrl_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_idle inCtrl_ready=%b expected=1", inCtrl_ready);
        end
        cfg_base      = base;
        cfg_step      = step;
        cfg_count     = count[15:0];
        inCtrl_valid  = 1'b1;
        out0_ready    = 1'b0;
        outCtrl_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        inCtrl_valid = hold_valid;
        cfg_base     = {$urandom, $urandom};
        cfg_step     = {$urandom, $urandom};
        cfg_count    = 16'($urandom);
        k      = 0;
        cyc    = 0;
        budget = (count + 1) * 64 + 64;
        while (k <= count && cyc < budget) begin
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else           rdy = (cyc < pat_len) ? pat[cyc] : 1'b1;
            exp_e = (k == count);
            exp_d = exp_e ? 64'd0 : base + 64'(k) * step;
            checks++;
            if ({out0_valid, out0_data_field1, out0_data_field0} !== {1'b1, exp_e, exp_d}) begin
                errors++;
                $display("FAIL beat%0d valid=%b eos=%b data=%h expected valid=1 eos=%b data=%h",
                         k, out0_valid, out0_data_field1, out0_data_field0, exp_e, exp_d);
            end
            checks++;
            if ({inCtrl_ready, outCtrl_valid} !== 2'b00) begin
                errors++;
                $display("FAIL run_side inCtrl_ready=%b outCtrl_valid=%b expected 0 0",
                         inCtrl_ready, outCtrl_valid);
            end
            out0_ready = rdy;
            @(posedge clock);
            @(negedge clock);
            if (rdy) k++;
            cyc++;
        end
        checks++;
        if (k <= count) begin
            errors++;
            $display("FAIL stream_timeout beats=%0d expected=%0d", k, count + 1);
        end
        out0_ready = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < ctrl_stall + 64) begin
            checks++;
            if ({outCtrl_valid, out0_valid, inCtrl_ready} !== 3'b100) begin
                errors++;
                $display("FAIL ctrl_phase outCtrl_valid=%b out0_valid=%b inCtrl_ready=%b expected 1 0 0",
                         outCtrl_valid, out0_valid, inCtrl_ready);
            end
            rdy = (cyc >= ctrl_stall);
            if (rdy) inCtrl_valid = 1'b0;
            outCtrl_ready = rdy;
            @(posedge clock);
            @(negedge clock);
            outCtrl_ready = 1'b0;
            done = rdy;
            cyc++;
        end
        checks++;
        if ({inCtrl_ready, outCtrl_valid, out0_valid} !== 3'b100) begin
            errors++;
            $display("FAIL back_to_idle inCtrl_ready=%b outCtrl_valid=%b out0_valid=%b expected 1 0 0",
                     inCtrl_ready, outCtrl_valid, out0_valid);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        inCtrl_valid  = 1'b0;
        out0_ready    = 1'b0;
        outCtrl_ready = 1'b0;
        cfg_base      = '0;
        cfg_step      = '0;
        cfg_count     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({inCtrl_ready, out0_valid, out0_data_field1, outCtrl_valid, out0_data_field0} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b eos=%b ctrl=%b data=%h expected 1 0 0 0 0",
                     inCtrl_ready, out0_valid, out0_data_field1, outCtrl_valid, out0_data_field0);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_stream(64'd5, 64'd3, 4, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_stream(64'd99, 64'd1, 0, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream(64'd0, 64'd1, 3, 0, 32'b1101001, 7, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_stream(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 3, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int          k;
        int          cyc;
        logic [63:0] exp_d;
        @(negedge clock);
        cfg_base     = 64'd100;
        cfg_step     = 64'd10;
        cfg_count    = 16'd10;
        inCtrl_valid = 1'b1;
        out0_ready   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inCtrl_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 16) begin
            exp_d = 64'd100 + 64'(k) * 64'd10;
            checks++;
            if (out0_valid !== 1'b1 || out0_data_field0 !== exp_d) begin
                errors++;
                $display("FAIL pre_reset_beat%0d valid=%b data=%h expected 1 %h",
                         k, out0_valid, out0_data_field0, exp_d);
            end
            @(posedge clock);
            @(negedge clock);
            k++;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({inCtrl_ready, out0_valid, out0_data_field1, outCtrl_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset ready=%b valid=%b eos=%b ctrl=%b expected 1 0 0 0",
                     inCtrl_ready, out0_valid, out0_data_field1, outCtrl_valid);
        end
        reset      = 1'b0;
        out0_ready = 1'b0;
        run_stream(64'd7, 64'd0, 2, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic test_ctrl_stall();
        run_stream(64'd1, 64'd2, 2, 0, 32'd0, 0, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            run_stream({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 20)),
                       1, 32'd0, 0, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_max_count();
        run_stream(64'd1000, 64'h0000_0001_0000_0001, 65535, 0, 32'd0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_wrap();
        test_reset_mid_run();
        test_ctrl_stall();
        test_random();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
